// File: rtl/alu_issue_sequencer.sv
// Issue front end for the 19-bit ALU: handshake, register file,
// operand presentation, latency wait and writeback with N/Z flags.
module alu_issue_sequencer #(
  parameter int DATA_W  = 19,
  parameter int NREGS   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_negative,
  output logic              wb_valid,
  output logic [3:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              illegal,
  input  logic              ld_we,
  input  logic [3:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] rf [NREGS];
  logic [16:0]       ir;
  logic [CW-1:0]     cnt;

  logic [4:0] opc;
  logic [3:0] rd, rs1, rs2;
  logic       accept, bad, cnt_last, ld_ok;
  logic       unused_bits;

  assign unused_bits = &{1'b0, instr[1:0]};

  assign opc = ir[16:12];
  assign rd  = ir[11:8];
  assign rs1 = ir[7:4];
  assign rs2 = ir[3:0];

  assign bad      = opc > 5'd12;
  assign cnt_last = cnt == CW'(1);

  // illegal keeps the sequencer busy one extra cycle
  assign instr_ready = rst_n & (state == IDLE) & ~illegal;
  assign accept      = instr_valid & instr_ready;

  assign ld_ok = (state == IDLE) & ld_we & ~accept
               & (ld_addr != 4'd0);

  assign wb_valid = state == WB;
  assign wb_addr  = wb_valid ? rd : 4'd0;

  assign dbg_data = (dbg_addr == 4'd0) ? '0 : rf[dbg_addr];

  function automatic logic [DATA_W-1:0] rd_rf(
    input logic [3:0] a
  );
    return (a == 4'd0) ? '0 : rf[a];
  endfunction

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = DECODE;
      DECODE:  state_nx = bad ? IDLE : EXEC;
      EXEC:    if (cnt_last) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      wb_data  <= '0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      illegal <= (state == DECODE) & bad;
      if (accept) ir <= instr[18:2];
      if (state == DECODE && !bad) begin
        alu_a    <= rd_rf(rs1);
        alu_b    <= rd_rf(rs2);
        alu_ctrl <= opc;
        cnt      <= CW'(ALU_LAT);
      end
      if (state == EXEC) begin
        cnt <= cnt - CW'(1);
        if (cnt_last) begin
          wb_data <= alu_result;
          flag_n  <= alu_negative;
          flag_z  <= alu_result == '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (state == WB) begin
      if (rd != 4'd0) rf[rd] <= wb_data;
    end else if (ld_ok) begin
      rf[ld_addr] <= ld_data;
    end
  end

endmodule

// File: doc/alu_issue_sequencer.md
# alu_issue_sequencer

Instruction-issue front end that drives the 19-bit combinational ALU. It accepts one 19-bit instruction at a time over a valid/ready handshake and reads two operands from a 16 x 19 register file. It presents A, B and the 5-bit ALU control code to the ALU, waits a programmable number of cycles, then captures Result and Negative and writes the result back. It sits between the fetch stage and the ALU in the 19-bit CPU datapath and owns the architectural register file and the N/Z status flags.

## Interface
- DATA_W, 19, datapath width; fixed at 19 for this CPU.
- NREGS, 16, register count; register address width is 4.
- ALU_LAT, 1, EXEC cycles before the ALU result is sampled; must be >= 1. It exists so a pipelined ALU can be used later.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  19  [18:14] opcode, [13:10] rd, [9:6] rs1, [5:2] rs2, [1:0] ignored.
- alu_a, alu_b  out  19  operands to ALU (registered).
- alu_ctrl  out  5  ALU control code (registered).
- alu_result  in  19  ALU Result.
- alu_negative  in  1  ALU Negative.
- wb_valid  out  1  one-cycle pulse: writeback occurring.
- wb_addr  out  4  destination register of that writeback.
- wb_data  out  19  value being written back.
- flag_n, flag_z  out  1  status from the last completed writeback.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- ld_we  in  1  register-file load strobe; honoured only in IDLE.
- ld_addr  in  4  load address.
- ld_data  in  19  load data.
- dbg_addr  in  4  debug read address.
- dbg_data  out  19  combinational rf[dbg_addr]; reads 0 when dbg_addr = 0.

## Operation
- **Register file:** 16 x 19 flops.
  - r0 always reads 0; writes to r0 are discarded.
  - All registers clear to 0 on reset.
- **FSM states:** IDLE, DECODE, EXEC, WB.
- **IDLE**
  - instr_ready = 1 (0 while rst_n low; 0 in all other states).
  - instr_valid & instr_ready: latch instr, go to DECODE. ld_we is ignored that cycle (handshake wins).
  - ld_we without a handshake: rf[ld_addr] <= ld_data.
- **DECODE**
  - opcode > 5'd12: pulse illegal for one cycle, go to IDLE. No register, flag or ALU-output change.
  - Otherwise: alu_a <= rf[rs1], alu_b <= rf[rs2], alu_ctrl <= opcode, counter <= ALU_LAT, go to EXEC.
  - Opcodes 10–12 are legal pass-through codes; the ALU returns 0 for them.
- **EXEC**
  - Counter decrements each cycle.
  - At the edge where the counter is 1: wb_data <= alu_result, flag_n <= alu_negative, flag_z <= (alu_result == 0), go to WB.
- **WB**
  - wb_valid = 1 and wb_addr = rd for exactly this cycle.
  - At the closing edge: rf[rd] <= wb_data (unless rd = 0), go to IDLE.
- **ALU outputs:** alu_a, alu_b and alu_ctrl hold their last values outside EXEC.
- **Arithmetic:** no width handling in this block. Results are taken modulo 2^19 exactly as the ALU returns them.

## Timing
- **Reset** (asynchronous, immediate):
  - state IDLE.
  - alu_a, alu_b, alu_ctrl, wb_data, wb_addr = 0.
  - wb_valid, illegal, flag_n, flag_z = 0.
  - All registers = 0.
  - Any in-flight instruction is dropped with no writeback.
- **Legal instruction latency:** handshake at edge E0.
  - DECODE runs in the cycle after E0.
  - ALU inputs are valid from E1.
  - Result is sampled at E(1+ALU_LAT).
  - wb_valid is high in the cycle after E(1+ALU_LAT).
  - Register is written at E(2+ALU_LAT).
  - instr_ready rises after E(2+ALU_LAT).
  - Issue interval: ALU_LAT+3 cycles.
- **Illegal instruction latency:** illegal is high in the cycle after E1. instr_ready rises after E2.
- **Hazards:** none. The next DECODE always follows the prior register write.
- **Handshake rules:**
  - instr_valid held high while instr_ready = 0 is not accepted.
  - instr may change freely when no handshake occurs.

## Test plan
- **Load then add.**
  - Stimulus: ld r1 = 5, ld r2 = 3; issue 19'h00C48 (ADD r3, r1, r2), ALU_LAT = 1.
  - Response:
    - alu_a = 5, alu_b = 3, alu_ctrl = 0 from E1.
    - wb_valid in the cycle after E2, with wb_addr = 3, wb_data = 8.
    - flag_n = 0, flag_z = 0; dbg r3 = 8.
- **Negative result.**
  - Stimulus: issue 19'h05084 (SUB r4, r2, r1) with r1 = 5, r2 = 3.
  - Response: wb_data = 19'h7FFFE, flag_n = 1, flag_z = 0, r4 = 19'h7FFFE.
- **Illegal opcode.**
  - Stimulus: issue 19'h34000 (opcode 13).
  - Response:
    - illegal pulses for exactly 1 cycle, and wb_valid never asserts.
    - Registers and flags are unchanged.
    - instr_ready returns after E2.
- **r0 destination.**
  - Stimulus: INC r0, r1 (r1 = 5).
  - Response: wb_valid with wb_addr = 0, wb_data = 6; dbg r0 = 0 afterwards.
- **Back-to-back and load blocking.**
  - Stimulus: ALU_LAT = 4; hold instr_valid high with two ADDs; pulse ld_we during EXEC.
  - Response:
    - The second instruction is accepted exactly 7 cycles after the first.
    - The ld_we pulse has no effect.
    - Each instruction produces exactly one wb_valid pulse.
- **Reset mid-operation.**
  - Stimulus: ALU_LAT = 4; assert rst_n = 0 during the second EXEC cycle.
  - Response:
    - All outputs go to 0 immediately, with no writeback.
    - dbg reads 0 for all registers.
    - instr_ready = 1 in the first cycle after rst_n rises.
